// File: rtl/ndarray_slice_reader_if.sv
// Handshake bundle between the frame producer / window consumer and ndarray_slice_reader.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high; valid never waits on ready.
interface ndarray_slice_reader_if #(
    parameter int ROWS  = 3,
    parameter int BITS  = 2,
    parameter int WIN   = 2,
    parameter int OFF_W = 3
);
    logic                       wr_valid;
    logic                       wr_ready;
    logic [ROWS*BITS-1:0]       wr_data;
    logic                       rd_req_valid;
    logic                       rd_req_ready;
    logic [OFF_W-1:0]           rd_off;
    logic                       rd_valid;
    logic                       rd_ready;
    logic [WIN*ROWS*BITS-1:0]   rd_data;
    logic                       frame_release;

    modport master (
        output wr_valid, wr_data, rd_req_valid, rd_off, rd_ready, frame_release,
        input  wr_ready, rd_req_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_req_valid, rd_off, rd_ready, frame_release,
        output wr_ready, rd_req_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/ndarray_slice_reader.sv
// Buffers one N-element frame, then serves zero-filled WIN-element slices at a dynamic offset.
// frame_release discards the frame once no slice is in flight.
module ndarray_slice_reader #(
    parameter int N     = 6,
    parameter int WIN   = 2,
    parameter int ROWS  = 3,
    parameter int BITS  = 2,
    parameter int OFF_W = 3
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESETN,
    ndarray_slice_reader_if.slave bus,
    output logic                 dbg_state,
    output logic [OFF_W-1:0]     dbg_wr_cnt
);
    localparam int EW = ROWS * BITS;
    localparam int SW = WIN * EW;
    localparam int IW = OFF_W + 1;
    localparam logic [OFF_W-1:0] LAST = OFF_W'(N - 1);

    typedef enum logic { FILL = 1'b0, SERVE = 1'b1 } state_t;

    state_t            state;
    logic [OFF_W-1:0]  wr_cnt;
    logic [EW-1:0]     frame_mem [N];
    logic              rd_valid_q;
    logic [SW-1:0]     rd_data_q;
    logic [SW-1:0]     slice;
    logic [IW-1:0]     idx;
    logic              req_acc;

    assign bus.wr_ready     = (state == FILL);
    assign bus.rd_req_ready = (state == SERVE) && (!rd_valid_q || bus.rd_ready);
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = rd_data_q;
    assign req_acc          = bus.rd_req_valid && bus.rd_req_ready;
    assign dbg_state        = state;
    assign dbg_wr_cnt       = wr_cnt;

    // Index is one bit wider than the offset so off+k never wraps back into the frame.
    always_comb begin
        slice = '0;
        idx   = '0;
        for (int k = 0; k < WIN; k++) begin
            idx = IW'(bus.rd_off) + IW'(k);
            if (idx < IW'(N)) begin
                slice[k*EW +: EW] = frame_mem[idx[OFF_W-1:0]];
            end
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state      <= FILL;
            wr_cnt     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            for (int i = 0; i < N; i++) begin
                frame_mem[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (bus.wr_valid) begin
                        frame_mem[wr_cnt] <= bus.wr_data;
                        if (wr_cnt == LAST) begin
                            wr_cnt <= '0;
                            state  <= SERVE;
                        end else begin
                            wr_cnt <= wr_cnt + OFF_W'(1);
                        end
                    end
                end
                SERVE: begin
                    if (req_acc) begin
                        rd_data_q  <= slice;
                        rd_valid_q <= 1'b1;
                    end else if (bus.rd_ready) begin
                        rd_valid_q <= 1'b0;
                    end
                    // A pending or just-accepted slice takes priority; release must be held.
                    if (bus.frame_release && !rd_valid_q && !req_acc) begin
                        state  <= FILL;
                        wr_cnt <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule
